// File: rtl/alu_seq_unit.sv
// Multi-cycle unsigned ALU: single-cycle add/sub, shift-add multiply, restoring divide.
// Valid/ready on both sides; results and flags held in DONE until the consumer accepts them.
module alu_seq_unit #(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rem,
    output logic             carry,
    output logic             ovf,
    output logic             err
);

    // state | meaning
    // IDLE  | waiting for an op, in_ready=1
    // MUL   | shift-add iterations, one multiplier bit per cycle
    // DIV   | restoring division, one quotient bit per cycle, MSB first
    // DONE  | result and flags held, out_valid=1 until out_ready

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [4:0] OP_ADD = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01000;
    localparam logic [4:0] OP_DIV = 5'b01011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic             last_iter;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;
    logic [WIDTH-1:0] div_hi_n;
    logic [WIDTH-1:0] div_lo_n;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last_iter = (cnt == CW'(1));

    assign add_sum = {1'b0, a} + {1'b0, b};

    // Multiply: hi:lo holds partial product over the not-yet-consumed multiplier bits in lo.
    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], lo[WIDTH-1:1]};

    // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    assign div_shift = {hi, lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_hi_n  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo_n  = {lo[WIDTH-2:0], div_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    case (s)
                        OP_MUL:  state_n = MUL;
                        OP_DIV:  state_n = (b == '0) ? DONE : DIV;
                        default: state_n = DONE;
                    endcase
                end
            end
            MUL, DIV: begin
                if (last_iter) state_n = DONE;
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= '0;
            rem   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            err   <= 1'b0;
            opnd  <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out   <= '0;
                        rem   <= '0;
                        carry <= 1'b0;
                        ovf   <= 1'b0;
                        err   <= 1'b0;
                        case (s)
                            OP_ADD: begin
                                out   <= add_sum[WIDTH-1:0];
                                carry <= add_sum[WIDTH];
                            end
                            OP_SUB: begin
                                out   <= a - b;
                                carry <= (a < b);
                            end
                            OP_MUL: begin
                                opnd <= a;
                                hi   <= '0;
                                lo   <= b;
                                cnt  <= CW'(WIDTH);
                            end
                            OP_DIV: begin
                                if (b == '0) begin
                                    out <= '1;
                                    rem <= a;
                                    err <= 1'b1;
                                end else begin
                                    opnd <= b;
                                    hi   <= '0;
                                    lo   <= a;
                                    cnt  <= CW'(WIDTH);
                                end
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                MUL: begin
                    hi  <= mul_hi_n;
                    lo  <= mul_lo_n;
                    cnt <= cnt - CW'(1);
                    if (last_iter) begin
                        out <= mul_lo_n;
                        ovf <= |mul_hi_n;
                    end
                end
                DIV: begin
                    hi  <= div_hi_n;
                    lo  <= div_lo_n;
                    cnt <= cnt - CW'(1);
                    if (last_iter) begin
                        out <= div_lo_n;
                        rem <= div_hi_n;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed WIDTH=8 vectors plus a WIDTH=40 instance checked
// against a behavioural model with random ops and random result stalls.
module tb_alu_seq_unit;

    localparam logic [4:0] OP_ADD = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01000;
    localparam logic [4:0] OP_DIV = 5'b01011;
    localparam logic [4:0] OP_BAD = 5'b00111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       iv8, ir8, ov8, or8, c8, v8, e8;
    logic [7:0] a8, b8, o8, r8;
    logic [4:0] s8;

    logic        iv40, ir40, ov40, or40, c40, v40, e40;
    logic [39:0] a40, b40, o40, r40;
    logic [4:0]  s40;

    int n_checks = 0;
    int n_pass   = 0;

    alu_seq_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .s(s8),
        .out_valid(ov8), .out_ready(or8), .out(o8), .rem(r8), .carry(c8), .ovf(v8), .err(e8)
    );

    alu_seq_unit #(.WIDTH(40)) dut40 (
        .clk(clk), .rst(rst), .in_valid(iv40), .in_ready(ir40), .a(a40), .b(b40), .s(s40),
        .out_valid(ov40), .out_ready(or40), .out(o40), .rem(r40), .carry(c40), .ovf(v40), .err(e40)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one op on the 8-bit unit; returns edges from accept to out_valid (accept edge = 1).
    task automatic op8(input logic [4:0] op, input logic [7:0] x, input logic [7:0] y, output int edges);
        s8 = op; a8 = x; b8 = y; iv8 = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        iv8 = 1'b0; a8 = ~x; b8 = 8'h5A; s8 = OP_SUB;
        while (!ov8 && edges < 64) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic pop8;
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    task automatic res8(input string tag, input int edges, input int lat,
                        input logic [7:0] eo, input logic [7:0] er, input logic [2:0] ef);
        check({tag, "_lat"},   64'(edges), 64'(lat));
        check({tag, "_out"},   64'(o8), 64'(eo));
        check({tag, "_rem"},   64'(r8), 64'(er));
        check({tag, "_flags"}, 64'({c8, v8, e8}), 64'(ef));
        pop8();
    endtask

    task automatic op40(input logic [4:0] op, input logic [39:0] x, input logic [39:0] y, output int edges);
        s40 = op; a40 = x; b40 = y; iv40 = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        iv40 = 1'b0; a40 = ~x; b40 = ~y; s40 = OP_ADD;
        while (!ov40 && edges < 128) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic model40(input logic [4:0] op, input logic [39:0] x, input logic [39:0] y,
                           output logic [39:0] eo, output logic [39:0] er, output logic [2:0] ef,
                           output int lat);
        logic [79:0] p;
        logic [40:0] sum;
        eo = '0; er = '0; ef = 3'b000; lat = 1;
        case (op)
            OP_ADD: begin
                sum = {1'b0, x} + {1'b0, y};
                eo = sum[39:0];
                ef[2] = sum[40];
            end
            OP_SUB: begin
                eo = x - y;
                ef[2] = (x < y);
            end
            OP_MUL: begin
                p = {40'd0, x} * {40'd0, y};
                eo = p[39:0];
                ef[1] = (p[79:40] != 40'd0);
                lat = 41;
            end
            OP_DIV: begin
                if (y == 40'd0) begin
                    eo = '1; er = x; ef[0] = 1'b1;
                end else begin
                    eo = x / y; er = x % y; lat = 41;
                end
            end
            default: ef[0] = 1'b1;
        endcase
    endtask

    task automatic run40(input string tag, input logic [4:0] op, input logic [39:0] x,
                         input logic [39:0] y, input int stall);
        logic [39:0] eo, er;
        logic [2:0]  ef;
        int          lat, edges;
        model40(op, x, y, eo, er, ef, lat);
        op40(op, x, y, edges);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        check({tag, "_lat"},   64'(edges), 64'(lat));
        check({tag, "_out"},   64'(o40), 64'(eo));
        check({tag, "_rem"},   64'(r40), 64'(er));
        check({tag, "_flags"}, 64'({c40, v40, e40}), 64'(ef));
        or40 = 1'b1;
        @(posedge clk); #1;
        or40 = 1'b0;
    endtask

    initial begin
        int          e;
        logic [4:0]  ops [6];
        logic [39:0] x, y;
        logic [4:0]  op;

        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_MUL;
        ops[3] = OP_DIV; ops[4] = OP_BAD; ops[5] = OP_DIV;

        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; s8 = '0;
        iv40 = 1'b0; or40 = 1'b0; a40 = '0; b40 = '0; s40 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hs",   64'({ir8, ov8}), 64'(2'b10));
        check("rst_out",  64'({o8, r8}), 64'd0);
        check("rst_flag", 64'({c8, v8, e8}), 64'd0);
        rst = 1'b0;

        op8(OP_ADD, 8'h0B, 8'h03, e); res8("add",     e, 1, 8'h0E, 8'h00, 3'b000);
        op8(OP_SUB, 8'h0B, 8'h03, e); res8("sub",     e, 1, 8'h08, 8'h00, 3'b000);
        op8(OP_SUB, 8'h03, 8'h0B, e); res8("sub_brw", e, 1, 8'hF8, 8'h00, 3'b100);
        op8(OP_ADD, 8'hFF, 8'h01, e); res8("add_cy",  e, 1, 8'h00, 8'h00, 3'b100);
        op8(OP_MUL, 8'h0B, 8'h03, e); res8("mul",     e, 9, 8'h21, 8'h00, 3'b000);
        op8(OP_MUL, 8'h20, 8'h10, e); res8("mul_ovf", e, 9, 8'h00, 8'h00, 3'b010);
        op8(OP_DIV, 8'h0B, 8'h03, e); res8("div",     e, 9, 8'h03, 8'h02, 3'b000);
        op8(OP_DIV, 8'hFF, 8'h10, e); res8("div_big", e, 9, 8'h0F, 8'h0F, 3'b000);
        op8(OP_DIV, 8'h0B, 8'h00, e); res8("div0",    e, 1, 8'hFF, 8'h0B, 3'b001);
        op8(OP_BAD, 8'h0B, 8'h03, e); res8("illegal", e, 1, 8'h00, 8'h00, 3'b001);

        // Backpressure: result must hold while a new request is pending.
        op8(OP_MUL, 8'h0F, 8'h0F, e);
        check("bp_lat", 64'(e), 64'd9);
        s8 = OP_ADD; a8 = 8'h01; b8 = 8'h02; iv8 = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_hold", 64'({ov8, ir8, o8, c8, v8, e8}), 64'({1'b1, 1'b0, 8'hE1, 3'b000}));
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        check("bp_release", 64'({ov8, ir8}), 64'(2'b01));
        @(posedge clk); #1;
        iv8 = 1'b0;
        check("bp_next", 64'({ov8, o8, c8}), 64'({1'b1, 8'h03, 1'b0}));
        pop8();

        // Reset while a result is held, then reset mid-multiply.
        op8(OP_ADD, 8'h0B, 8'h03, e);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_done", 64'({ov8, ir8, o8, r8, c8, v8, e8}), 64'({1'b0, 1'b1, 8'h00, 8'h00, 3'b000}));

        s8 = OP_MUL; a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mul", 64'({ov8, ir8, o8, r8, c8, v8, e8}), 64'({1'b0, 1'b1, 8'h00, 8'h00, 3'b000}));
        repeat (12) @(posedge clk);
        #1;
        check("rst_no_result", 64'({ov8, ir8}), 64'(2'b01));
        op8(OP_ADD, 8'h21, 8'h05, e); res8("post_rst_add", e, 1, 8'h26, 8'h00, 3'b000);

        run40("w40_add", OP_ADD, 40'h000000000B, 40'h0000000003, 0);
        run40("w40_sub", OP_SUB, 40'h000000000B, 40'h0000000003, 0);
        run40("w40_mul", OP_MUL, 40'h000000000B, 40'h0000000003, 0);
        run40("w40_div", OP_DIV, 40'h000000000B, 40'h0000000003, 0);
        run40("w40_mul_max", OP_MUL, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 2);

        for (int i = 0; i < 1000; i++) begin
            op = ops[$urandom_range(0, 5)];
            x = 40'({$urandom(), $urandom()});
            y = 40'({$urandom(), $urandom()});
            if ($urandom_range(0, 1) == 1) x = x >> $urandom_range(0, 39);
            if ($urandom_range(0, 1) == 1) y = y >> $urandom_range(0, 39);
            if ($urandom_range(0, 15) == 0) y = '0;
            run40("w40_rand", op, x, y, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
